// File: rtl/delayline_mux.sv
// delayline_mux
//   Shares one simple-dual-port BRAM between N_CH independent delay lines.
//   Each accepted strobe snapshots all inputs and delays, then walks the
//   channels issuing one write and one read per cycle. Once every read has
//   returned, all channel outputs are published together with a done pulse.
//
// Ports
//   clk      system clock
//   rst      synchronous, active-high reset
//   strobe   one-cycle sample-rate pulse
//   delay    packed per-channel delays ($clog2(MAX_DELAY) bits each, ch0 LSBs)
//   in       packed signed input samples (W bits each, ch0 LSBs)
//   out      packed signed delayed samples, updated atomically
//   busy     high while a sequence is in progress
//   done     one-cycle pulse in the cycle out takes its new value
//   overrun  sticky; a strobe arrived while a sequence was in progress
module delayline_mux #(
    parameter int W         = 16,
    parameter int MAX_DELAY = 1024,
    parameter int N_CH      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 strobe,
    input  logic [N_CH*$clog2(MAX_DELAY)-1:0]    delay,
    input  logic [N_CH*W-1:0]                    in,
    output logic [N_CH*W-1:0]                    out,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overrun
);

    localparam int AW = $clog2(MAX_DELAY);
    localparam int CW = $clog2(N_CH);
    localparam int FW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, PUBLISH} state_t;

    // A programmed delay of zero behaves as one sample.
    function automatic logic [AW-1:0] eff_delay(input logic [AW-1:0] d);
        return (d == '0) ? AW'(1) : d;
    endfunction

    // Fill counter saturates at MAX_DELAY.
    function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] f);
        return (f == FW'(MAX_DELAY)) ? f : f + 1'b1;
    endfunction

    // Control state (reset)
    state_t              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic [N_CH*W-1:0]   out_q, out_d;
    logic                rd_vld_q, rd_vld_d;
    logic [CW-1:0]       rd_ch_q, rd_ch_d;

    // Datapath state (no reset)
    logic [N_CH*W-1:0]   in_hold_q, in_hold_d;
    logic [N_CH*AW-1:0]  dly_hold_q, dly_hold_d;
    logic [N_CH*W-1:0]   shadow_q, shadow_d;

    // BRAM
    logic signed [W-1:0] mem [0:N_CH*MAX_DELAY-1];
    logic signed [W-1:0] rdata_q;
    logic                we;
    logic [AW-1:0]       rd_ptr;
    logic [CW+AW-1:0]    wr_addr;
    logic [CW+AW-1:0]    rd_addr;

    assign we      = (state_q == RUN);
    assign rd_ptr  = waddr_q - eff_delay(dly_hold_q[ch_q*AW +: AW]);
    assign wr_addr = {ch_q, waddr_q};
    assign rd_addr = {ch_q, rd_ptr};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= in_hold_q[ch_q*W +: W];
        end
        rdata_q <= mem[rd_addr];
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        waddr_d    = waddr_q;
        fill_d     = fill_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
        out_d      = out_q;
        in_hold_d  = in_hold_q;
        dly_hold_d = dly_hold_q;
        shadow_d   = shadow_q;
        rd_vld_d   = (state_q == RUN);
        rd_ch_d    = ch_q;

        // Read data returns one cycle after issue, tagged with its channel.
        if (rd_vld_q) begin
            shadow_d[rd_ch_q*W +: W] = rdata_q;
        end

        if (strobe && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (strobe) begin
                    in_hold_d  = in;
                    dly_hold_d = delay;
                    busy_d     = 1'b1;
                    ch_d       = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                ch_d = ch_q + 1'b1;
                if (ch_q == CW'(N_CH - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Use shadow_d so the final read, landing this cycle, is
                // included; out and done then appear together in PUBLISH.
                // Channels whose history is shorter than their delay read 0.
                for (int c = 0; c < N_CH; c++) begin
                    if (fill_q < {1'b0, eff_delay(dly_hold_q[c*AW +: AW])}) begin
                        out_d[c*W +: W] = '0;
                    end else begin
                        out_d[c*W +: W] = shadow_d[c*W +: W];
                    end
                end
                done_d  = 1'b1;
                state_d = PUBLISH;
            end
            PUBLISH: begin
                waddr_d = waddr_q + 1'b1;
                fill_d  = sat_inc(fill_q);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            waddr_q   <= '0;
            fill_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            out_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_ch_q   <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            waddr_q   <= waddr_d;
            fill_q    <= fill_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            out_q     <= out_d;
            rd_vld_q  <= rd_vld_d;
            rd_ch_q   <= rd_ch_d;
        end
    end

    always_ff @(posedge clk) begin
        in_hold_q  <= in_hold_d;
        dly_hold_q <= dly_hold_d;
        shadow_q   <= shadow_d;
    end

    assign out     = out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_delayline_mux.sv
module tb_delayline_mux;

    localparam int W  = 16;
    localparam int MD = 1024;
    localparam int NC = 4;
    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              strobe;
    logic [NC*AW-1:0]  delay;
    logic [NC*W-1:0]   in_v;
    logic [NC*W-1:0]   out;
    logic              busy;
    logic              done;
    logic              overrun;

    int          checks = 0;
    int          errors = 0;
    int          dl[NC];
    int          k;
    logic [15:0] hist[NC][2200];

    always #5 clk = ~clk;

    delayline_mux #(.W(W), .MAX_DELAY(MD), .N_CH(NC)) dut (
        .clk     (clk),
        .rst     (rst),
        .strobe  (strobe),
        .delay   (delay),
        .in      (in_v),
        .out     (out),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_ch(input int c);
        return {16'h0, out[c*W +: W]};
    endfunction

    // Reference: output at strobe k is the input from strobe k-D, or 0 before that.
    function automatic logic [15:0] model(input int c);
        int d;
        d = (dl[c] == 0) ? 1 : dl[c];
        if (k >= d) return hist[c][k-d];
        return 16'h0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
    endtask

    // One full sequence; inj>0 fires an extra strobe that many cycles after the accepted one.
    task automatic do_strobe(input logic [15:0] v0, input logic [15:0] v1,
                             input logic [15:0] v2, input logic [15:0] v3,
                             input int gap, input int inj);
        logic [15:0] v[NC];
        int lat;
        v = '{v0, v1, v2, v3};
        for (int c = 0; c < NC; c++) begin
            hist[c][k]      = v[c];
            in_v[c*W +: W]  = v[c];
            delay[c*AW +: AW] = AW'(dl[c]);
        end
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        check("busy_set", 32'(busy), 32'd1);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            if (lat == inj) begin
                strobe = 1'b1;
                in_v   = {NC{16'h7777}};
            end
            @(posedge clk);
            #1;
            strobe = 1'b0;
            lat++;
        end
        check("done_latency", 32'(lat), 32'd6);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("out_k%0d_ch%0d", k, c), out_ch(c), {16'h0, model(c)});
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        k++;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // Impulse on ch0 with delay 3, others delay 5, strobes 10 cycles apart.
    task automatic run_impulse();
        dl = '{3, 5, 5, 5};
        k  = 0;
        for (int i = 0; i < 6; i++) begin
            do_strobe((i == 0) ? 16'd1000 : 16'd0, 16'd0, 16'd0, 16'd0, 3, 0);
            check($sformatf("impulse_ch0_s%0d", i), out_ch(0), (i == 3) ? 32'd1000 : 32'd0);
            check($sformatf("impulse_ch3_s%0d", i), out_ch(3), 32'd0);
        end
    endtask

    initial begin
        bit saw_done;
        rst    = 1'b1;
        strobe = 1'b0;
        in_v   = '0;
        delay  = '0;
        k      = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_out", out_ch(0) | out_ch(1) | out_ch(2) | out_ch(3), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);

        run_impulse();

        // Independent delays and ramps, long enough to wrap the write pointer twice.
        do_reset();
        dl = '{1, 2, 7, 1023};
        for (int kk = 0; kk < 2100; kk++) begin
            do_strobe(16'(kk), 16'(kk + 100), 16'(kk + 200), 16'(kk + 300), 0, 0);
            if (kk == 6)    check("ch2_before_fill", out_ch(2), 32'd0);
            if (kk == 7)    check("ch2_first", out_ch(2), 32'd200);
            if (kk == 1022) check("ch3_before_fill", out_ch(3), 32'd0);
            if (kk == 1023) check("ch3_first", out_ch(3), 32'd300);
            if (kk == 2046) check("ch3_wrap", out_ch(3), 32'd1323);
        end
        check("ch0_final", out_ch(0), 32'd2098);
        check("ch3_final", out_ch(3), 32'd1376);

        // delay=0 on ch2 behaves as delay=1; negative samples.
        do_reset();
        dl = '{1, 1, 0, 3};
        for (int kk = 0; kk < 8; kk++) begin
            do_strobe(16'(-(kk*37 + 5)), 16'(kk), 16'(-(kk*37 + 5)), 16'(kk), 0, 0);
            check($sformatf("dly0_ch2_k%0d", kk), out_ch(2),
                  (kk == 0) ? 32'd0 : {16'h0, 16'(-((kk-1)*37 + 5))});
        end

        // Overrun: extra strobe 3 cycles into a sequence is ignored.
        do_strobe(16'd11, 16'd22, 16'd33, 16'd44, 0, 3);
        check("overrun_set", 32'(overrun), 32'd1);
        do_strobe(16'd55, 16'd66, 16'd77, 16'd88, 0, 0);
        check("overrun_ch0_prev", out_ch(0), 32'd11);
        check("overrun_ch2_prev", out_ch(2), 32'd33);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset two cycles into a sequence aborts it.
        dl = '{3, 5, 5, 5};
        for (int c = 0; c < NC; c++) delay[c*AW +: AW] = AW'(dl[c]);
        in_v = {16'd0, 16'd0, 16'd0, 16'd1234};
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_out", out_ch(0) | out_ch(1) | out_ch(2) | out_ch(3), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_busy_clear", 32'(busy), 32'd0);

        run_impulse();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
